ahb_cmd_master: RTL and testbench

Command-driven AHB-Lite master that turns single read/write requests into AHB transfers. It sits directly upstream of the AHB slave memory model and drives its HSEL/HADDR/HTRANS/HWDATA inputs. It consumes HRDATA, HREADYOUT and HRESP from that slave. Test sequencers or the UART command decoder use it to reach slave memory with one transfer in flight and a valid/ready handshake on both the command and response sides.

---
 rtl/ahb_cmd_pkg.sv | 35 +++
 rtl/ahb_lane_steer.sv | 33 +++
 rtl/ahb_cmd_master.sv | 142 ++++++++++++++
 tb/tb_ahb_cmd_master.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_cmd_pkg.sv
// Shared AHB-Lite encodings, FSM state type and command legality check
// for the command-driven AHB master.
package ahb_cmd_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_RESP
   } state_t;

   // Legal size and natural alignment; anything else is answered without a bus transfer.
   function automatic logic cmd_legal(input logic [1:0] size, input logic [1:0] addr_lo);
      logic ok;
      ok = 1'b0;
      case ({1'b0, size})
         HSIZE_BYTE: ok = 1'b1;
         HSIZE_HALF: ok = (addr_lo[0] == 1'b0);
         HSIZE_WORD: ok = (addr_lo == 2'b00);
         default:    ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/ahb_lane_steer.sv
// Byte-lane steering for a 32-bit AHB data bus: write-data replication and
// right-justified, zero-extended read extraction from size and addr[1:0].
module ahb_lane_steer
   import ahb_cmd_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] bus_rdata,
   output logic [31:0] bus_wdata,
   output logic [31:0] rdata
);

   always_comb begin
      bus_wdata = wdata;
      rdata     = bus_rdata;
      case ({1'b0, size})
         HSIZE_BYTE: begin
            bus_wdata = {4{wdata[7:0]}};
            rdata     = {24'h0, bus_rdata[{addr_lo, 3'b000} +: 8]};
         end
         HSIZE_HALF: begin
            bus_wdata = {2{wdata[15:0]}};
            rdata     = {16'h0, bus_rdata[{addr_lo[1], 4'b0000} +: 16]};
         end
         default: begin
            bus_wdata = wdata;
            rdata     = bus_rdata;
         end
      endcase
   end

endmodule

// File: rtl/ahb_cmd_master.sv
// Single-outstanding AHB-Lite master: one command in, one SINGLE/NONSEQ
// transfer on the bus, one response out, with a sticky data-phase timeout flag.
module ahb_cmd_master
   import ahb_cmd_pkg::*;
#(
   parameter int unsigned AWIDTH  = 10,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              HCLK,
   input  logic              HRESETN,
   input  logic              CMD_VALID,
   output logic              CMD_READY,
   input  logic              CMD_WRITE,
   input  logic [AWIDTH-1:0] CMD_ADDR,
   input  logic [1:0]        CMD_SIZE,
   input  logic [31:0]       CMD_WDATA,
   output logic              RSP_VALID,
   input  logic              RSP_READY,
   output logic [31:0]       RSP_RDATA,
   output logic              RSP_ERR,
   output logic              TIMEOUT_FLAG,
   output logic              HSEL,
   output logic [AWIDTH-1:0] HADDR,
   output logic              HWRITE,
   output logic [1:0]        HTRANS,
   output logic [2:0]        HSIZE,
   output logic [2:0]        HBURST,
   output logic              HMASTLOCK,
   output logic [3:0]        HPROT,
   output logic [31:0]       HWDATA,
   input  logic              HREADY,
   input  logic [31:0]       HRDATA,
   input  logic              HRESP
);

   localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

   state_t              state, state_nxt;
   logic                lat_write;
   logic [AWIDTH-1:0]   lat_addr;
   logic [1:0]          lat_size;
   logic [31:0]         lat_wdata;
   logic [31:0]         rsp_rdata_q;
   logic                rsp_err_q;
   logic                rsp_hold;
   logic [15:0]         wait_cnt;
   logic                timeout_q;
   logic                cmd_ok;
   logic [31:0]         steer_wdata;
   logic [31:0]         steer_rdata;

   ahb_lane_steer u_steer (
      .size      (lat_size),
      .addr_lo   (lat_addr[1:0]),
      .wdata     (lat_wdata),
      .bus_rdata (HRDATA),
      .bus_wdata (steer_wdata),
      .rdata     (steer_rdata)
   );

   always_comb begin
      cmd_ok = cmd_legal(CMD_SIZE, CMD_ADDR[1:0]);
   end

   always_comb begin
      state_nxt    = state;
      CMD_READY    = 1'b0;
      RSP_VALID    = 1'b0;
      HSEL         = 1'b0;
      HTRANS       = HTRANS_IDLE;
      HADDR        = lat_addr;
      HWRITE       = lat_write;
      HSIZE        = {1'b0, lat_size};
      HWDATA       = steer_wdata;
      HBURST       = HBURST_SINGLE;
      HMASTLOCK    = 1'b0;
      HPROT        = HPROT_DEFAULT;
      RSP_RDATA    = rsp_rdata_q;
      RSP_ERR      = rsp_err_q;
      TIMEOUT_FLAG = timeout_q;
      case (state)
         ST_IDLE: begin
            CMD_READY = 1'b1;
            if (CMD_VALID) state_nxt = cmd_ok ? ST_ADDR : ST_RESP;
         end
         ST_ADDR: begin
            HSEL   = 1'b1;
            HTRANS = HTRANS_NONSEQ;
            if (HREADY) state_nxt = ST_DATA;
         end
         ST_DATA: begin
            if (HREADY) state_nxt = ST_RESP;
         end
         ST_RESP: begin
            // A rejected command spends one silent cycle here so its response lands one edge after acceptance.
            RSP_VALID = !rsp_hold;
            if (!rsp_hold && RSP_READY) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETN) begin
         state       <= ST_IDLE;
         lat_write   <= 1'b0;
         lat_addr    <= '0;
         lat_size    <= '0;
         lat_wdata   <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         rsp_hold    <= 1'b0;
         wait_cnt    <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state    <= state_nxt;
         rsp_hold <= 1'b0;
         if (state == ST_IDLE && CMD_VALID) begin
            lat_write <= CMD_WRITE;
            lat_addr  <= CMD_ADDR;
            lat_size  <= CMD_SIZE;
            lat_wdata <= CMD_WDATA;
            if (!cmd_ok) begin
               rsp_rdata_q <= '0;
               rsp_err_q   <= 1'b1;
               rsp_hold    <= 1'b1;
            end
         end
         if (state == ST_DATA && HREADY) begin
            rsp_err_q   <= HRESP;
            rsp_rdata_q <= lat_write ? '0 : steer_rdata;
         end
         if (state == ST_DATA && !HREADY) begin
            if (wait_cnt < TIMEOUT_CNT) wait_cnt <= wait_cnt + 16'd1;
            if (wait_cnt + 16'd1 >= TIMEOUT_CNT) timeout_q <= 1'b1;
         end else begin
            wait_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Scoreboard bench for ahb_cmd_master: random commands against a byte-array
// memory reference, a behavioural AHB slave, and a decoupled response monitor.
`timescale 1ns/1ps
module tb_ahb_cmd_master;

   localparam int unsigned AW  = 10;
   localparam int unsigned TMO = 8;

   logic          HCLK = 1'b0;
   logic          HRESETN;
   logic          CMD_VALID, CMD_READY, CMD_WRITE;
   logic [AW-1:0] CMD_ADDR;
   logic [1:0]    CMD_SIZE;
   logic [31:0]   CMD_WDATA;
   logic          RSP_VALID, RSP_READY, RSP_ERR, TIMEOUT_FLAG;
   logic [31:0]   RSP_RDATA;
   logic          HSEL, HWRITE, HMASTLOCK, HREADY, HRESP;
   logic [AW-1:0] HADDR;
   logic [1:0]    HTRANS;
   logic [2:0]    HSIZE, HBURST;
   logic [3:0]    HPROT;
   logic [31:0]   HWDATA, HRDATA;

   always #5 HCLK = ~HCLK;

   ahb_cmd_master #(.AWIDTH(AW), .TIMEOUT(TMO)) dut (
      .HCLK(HCLK), .HRESETN(HRESETN),
      .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
      .CMD_ADDR(CMD_ADDR), .CMD_SIZE(CMD_SIZE), .CMD_WDATA(CMD_WDATA),
      .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
      .RSP_ERR(RSP_ERR), .TIMEOUT_FLAG(TIMEOUT_FLAG),
      .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE),
      .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HWDATA(HWDATA),
      .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        flag;
      int unsigned cyc;
   } exp_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic          write;
      logic [1:0]    size;
      logic [31:0]   hwdata;
      int unsigned   waits;
      logic          err;
   } plan_t;

   exp_t        sb_q[$];
   plan_t       plan_q[$];
   int          checks   = 0;
   int          failures = 0;
   int unsigned cyc      = 0;
   logic [7:0]  ref_mem[1024];
   logic [7:0]  slv_mem[1024];
   logic        exp_flag = 1'b0;
   bit          slv_busy = 1'b0;

   always @(posedge HCLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
      end
   endtask

   // Issue one command; expectations come from the byte-array reference.
   task automatic do_cmd(input logic w, input logic [AW-1:0] a, input logic [1:0] sz,
                         input logic [31:0] wd, input int unsigned n, input logic er,
                         input bit expect_rsp);
      exp_t        e;
      plan_t       p;
      logic        legal;
      int unsigned nb;
      logic [31:0] rd;
      legal = (sz != 2'b11) && !(sz == 2'b01 && a[0]) && !(sz == 2'b10 && a[1:0] != 2'b00);
      nb    = 1 << sz;
      @(negedge HCLK);
      CMD_VALID = 1'b1; CMD_WRITE = w; CMD_ADDR = a; CMD_SIZE = sz; CMD_WDATA = wd;
      for (int k = 0; k < 400 && !CMD_READY; k++) @(negedge HCLK);
      if (!CMD_READY) begin
         checks++; failures++;
         $display("FAIL cmd_ready_timeout actual=0 required=1");
         CMD_VALID = 1'b0;
         return;
      end
      rd = '0;
      if (legal && !w)
         for (int unsigned i = 0; i < nb; i++) rd[8*i +: 8] = ref_mem[int'(a) + i];
      if (legal && w && !er)
         for (int unsigned i = 0; i < nb; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
      if (legal && (n + er) >= TMO) exp_flag = 1'b1;
      e.rdata = (legal && !w) ? rd : 32'h0;
      e.err   = legal ? er : 1'b1;
      e.flag  = exp_flag;
      e.cyc   = cyc + 1 + (legal ? 2 + n + er : 1);
      if (legal) begin
         p.addr  = a; p.write = w; p.size = sz; p.waits = n; p.err = er;
         p.hwdata = (sz == 2'b00) ? {4{wd[7:0]}} : (sz == 2'b01) ? {2{wd[15:0]}} : wd;
         plan_q.push_back(p);
      end
      if (expect_rsp) sb_q.push_back(e);
      @(posedge HCLK);
      #1 CMD_VALID = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((sb_q.size() != 0 || plan_q.size() != 0 || slv_busy) && k < 500) begin
         @(negedge HCLK);
         k++;
      end
      checks++;
      if (k >= 500) begin
         failures++;
         $display("FAIL drain_timeout actual=pending=%0d required=0", sb_q.size());
      end
   endtask

   // Behavioural AHB slave: follows the per-transfer plan for waits and errors.
   initial begin
      plan_t       p;
      logic [31:0] word;
      int unsigned base, nb, len, off;
      HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
      forever begin
         @(negedge HCLK);
         HREADY = 1'b1; HRESP = 1'b0;
         if (HRESETN && HSEL && HTRANS == 2'b10) begin
            if (plan_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_nonseq actual=addr 0x%03h required=no transfer", HADDR);
            end else begin
               p = plan_q.pop_front();
               slv_busy = 1'b1;
               check("haddr", 32'(HADDR), 32'(p.addr));
               check("hwrite", {31'd0, HWRITE}, {31'd0, p.write});
               check("hsize", {29'd0, HSIZE}, {30'd0, p.size});
               check("hburst_hprot_lock", {24'd0, HBURST, HPROT, HMASTLOCK}, {24'd0, 3'b000, 4'b0011, 1'b0});
               len  = p.waits + p.err + 1;
               nb   = 1 << p.size;
               base = {p.addr[AW-1:2], 2'b00};
               for (int unsigned k = 0; k < len; k++) begin
                  @(negedge HCLK);
                  if (k == 0) check("data_phase_idle", {29'd0, HSEL, HTRANS}, 32'h0);
                  HREADY = (k == len - 1);
                  HRESP  = p.err && (k + 2 >= len);
                  word   = {slv_mem[base+3], slv_mem[base+2], slv_mem[base+1], slv_mem[base]};
                  HRDATA = (k == len - 1) ? word : $urandom;
                  if (k == len - 1 && p.write) begin
                     check("hwdata", HWDATA, p.hwdata);
                     if (!p.err)
                        for (int unsigned i = 0; i < nb; i++) begin
                           off = (int'(p.addr) + i) % 4;
                           slv_mem[int'(p.addr) + i] = HWDATA[8*off +: 8];
                        end
                  end
               end
               slv_busy = 1'b0;
            end
         end
      end
   end

   // Response monitor: compares against the scoreboard head, stalls RSP_READY randomly.
   initial begin
      exp_t        e;
      bit          in_rsp;
      int unsigned stall;
      in_rsp = 1'b0; stall = 0; RSP_READY = 1'b0;
      forever begin
         @(negedge HCLK);
         if (!HRESETN) begin
            in_rsp = 1'b0; RSP_READY = 1'b0;
         end else if (RSP_VALID) begin
            if (sb_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_rsp actual=valid required=no response");
               RSP_READY = 1'b1;
            end else begin
               e = sb_q[0];
               if (!in_rsp) begin
                  check("rsp_latency", cyc, e.cyc);
                  in_rsp = 1'b1;
                  stall  = $urandom_range(0, 5);
               end
               check("rsp_rdata", RSP_RDATA, e.rdata);
               check("rsp_err", {31'd0, RSP_ERR}, {31'd0, e.err});
               check("timeout_flag", {31'd0, TIMEOUT_FLAG}, {31'd0, e.flag});
               check("cmd_ready_busy", {31'd0, CMD_READY}, 32'h0);
               if (stall > 0) begin
                  RSP_READY = 1'b0;
                  stall--;
               end else begin
                  RSP_READY = 1'b1;
                  void'(sb_q.pop_front());
                  in_rsp = 1'b0;
               end
            end
         end else begin
            RSP_READY = 1'($urandom % 2);
         end
      end
   end

   initial begin
      logic          w;
      logic [AW-1:0] a;
      logic [1:0]    sz;
      int unsigned   r;
      logic [7:0]    b;
      HRESETN = 1'b0; CMD_VALID = 1'b0; CMD_WRITE = 1'b0;
      CMD_ADDR = '0; CMD_SIZE = '0; CMD_WDATA = '0;
      for (int i = 0; i < 1024; i++) begin
         b = 8'($urandom);
         ref_mem[i] = b;
         slv_mem[i] = b;
      end
      repeat (3) @(negedge HCLK);
      HRESETN = 1'b1;
      @(negedge HCLK);
      check("reset_cmd_ready", {31'd0, CMD_READY}, 32'h1);
      check("reset_bus", {HSEL, HTRANS, HWRITE, HSIZE, 3'b000, HADDR, 12'h0}, 32'h0);
      check("reset_hwdata", HWDATA, 32'h0);
      check("reset_rsp", {RSP_RDATA[29:0], RSP_VALID, RSP_ERR}, 32'h0);
      check("reset_flag", {31'd0, TIMEOUT_FLAG}, 32'h0);

      do_cmd(1'b1, 10'h004, 2'b10, 32'hDEADBEEF, 0, 1'b0, 1'b1);
      do_cmd(1'b1, 10'h000, 2'b10, 32'hA5123456, 0, 1'b0, 1'b1);
      do_cmd(1'b0, 10'h003, 2'b00, 32'h0, 3, 1'b0, 1'b1);
      do_cmd(1'b1, 10'h002, 2'b01, 32'h0000BEEF, 1, 1'b0, 1'b1);
      do_cmd(1'b0, 10'h000, 2'b10, 32'h0, 0, 1'b0, 1'b1);
      do_cmd(1'b0, 10'h008, 2'b10, 32'h0, 0, 1'b1, 1'b1);
      do_cmd(1'b0, 10'h001, 2'b01, 32'h0, 0, 1'b0, 1'b1);
      do_cmd(1'b1, 10'h020, 2'b11, 32'h12345678, 0, 1'b0, 1'b1);
      drain();

      for (int t = 0; t < 60; t++) begin
         repeat ($urandom_range(0, 2)) @(negedge HCLK);
         r  = $urandom % 8;
         sz = (r < 3) ? 2'b00 : (r < 5) ? 2'b01 : (r < 7) ? 2'b10 : 2'b11;
         a  = AW'($urandom);
         if ($urandom % 4 != 0) begin
            if (sz == 2'b01) a[0] = 1'b0;
            if (sz == 2'b10) a[1:0] = 2'b00;
         end
         w = 1'($urandom % 2);
         do_cmd(w, a, sz, $urandom, $urandom_range(0, 3), 1'($urandom % 6 == 0), 1'b1);
      end
      drain();

      do_cmd(1'b0, 10'h010, 2'b10, 32'h0, TMO - 1, 1'b0, 1'b1);
      drain();
      check("flag_below_limit", {31'd0, TIMEOUT_FLAG}, 32'h0);
      do_cmd(1'b0, 10'h014, 2'b01, 32'h0, TMO, 1'b0, 1'b1);
      drain();
      check("flag_at_limit", {31'd0, TIMEOUT_FLAG}, 32'h1);

      // Reset lands in the data phase of a read whose response must never appear.
      do_cmd(1'b0, 10'h018, 2'b10, 32'h0, 6, 1'b0, 1'b0);
      @(negedge HCLK);
      @(negedge HCLK);
      HRESETN = 1'b0;
      @(negedge HCLK);
      check("rst_mid_bus", {28'd0, HSEL, HTRANS, RSP_VALID}, 32'h0);
      check("rst_mid_haddr", 32'(HADDR), 32'h0);
      repeat (8) @(negedge HCLK);
      exp_flag = 1'b0;
      HRESETN  = 1'b1;
      @(negedge HCLK);
      check("rst_release_ready", {30'd0, CMD_READY, TIMEOUT_FLAG}, 32'h2);
      repeat (5) @(negedge HCLK);
      check("rst_no_rsp", {31'd0, RSP_VALID}, 32'h0);

      do_cmd(1'b0, 10'h004, 2'b10, 32'h0, 1, 1'b0, 1'b1);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "simulation time limit");
   end

endmodule
